// File: rtl/toy_drv_pkg.sv
// Shared types and constants for the toy core warm-up/command driver.
// Contents: FSM state enum, 10-bit {op,data} word struct, default unlock key,
//           and a width helper for counters that must hold 0..max_val.
package toy_drv_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned OP_W        = 2;
  localparam int unsigned KEY_W       = DATA_W + OP_W;
  localparam int unsigned KEY_LEN_DEF = 4;

  typedef enum logic [2:0] {
    S_WARM,
    S_KEY,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ERR
  } state_t;

  // One word presented to the core: opcode in the upper bits, operand below.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
  } key_word_t;

  // Word 0 sits in the most significant slot and is played first.
  localparam logic [KEY_LEN_DEF*KEY_W-1:0] KEY_DEF =
    {10'h1A5, 10'h0C3, 10'h25A, 10'h33C};

  // Bits needed to represent every value in 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/toy_warmup_driver_if.sv
// Bundle of host command, core, and status signals around toy_warmup_driver.
// slave  : the driver itself (takes host commands and core completions).
// master : the surroundings (host plus core), i.e. the mirror view.
interface toy_warmup_driver_if;
  import toy_drv_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_data;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] core_datain;
  logic [OP_W-1:0]   core_op;
  logic              core_valid;
  logic [DATA_W-1:0] core_dataout;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              unlocked;
  logic              busy;
  logic              timeout_err;

  modport slave (
    input  cmd_valid, cmd_data, cmd_op, core_valid, core_dataout,
    output cmd_ready, core_datain, core_op, res_valid, res_data,
           unlocked, busy, timeout_err
  );

  modport master (
    output cmd_valid, cmd_data, cmd_op, core_valid, core_dataout,
    input  cmd_ready, core_datain, core_op, res_valid, res_data,
           unlocked, busy, timeout_err
  );

endinterface

// File: rtl/toy_cmd_fifo.sv
// Synchronous command FIFO with flush.
// Ports: clk, rst (sync, active-low), flush (empties FIFO, beats push/pop),
//        push/push_data, pop/pop_data_c (head word, valid when !empty_c),
//        full_c, empty_c (decoded from the registered count).
module toy_cmd_fifo
  import toy_drv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  key_word_t push_data,
  input  logic      pop,
  output key_word_t pop_data_c,
  output logic      full_c,
  output logic      empty_c
);

  localparam int unsigned PTR_W = cnt_width(DEPTH - 1);
  localparam int unsigned CNT_W = PTR_W + 1;

  key_word_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_c     = (count == CNT_W'(DEPTH));
  assign empty_c    = (count == '0);
  assign do_push    = push & ~full_c;
  assign do_pop     = pop & ~empty_c;
  assign pop_data_c = mem[rd_ptr];

  // Storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally; flush drops everything including a same-cycle push.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/toy_warmup_driver.sv
// Upstream command stage for the FSM-locked toy core.
// After reset it waits WARM_CYC cycles, plays the KEY words (HOLD_CYC cycles
// each) onto core_op/core_datain, then serves buffered host commands one at a
// time, returning each core result as a one-cycle res_valid beat. A command
// that sees no core_valid within TIMEOUT cycles locks the block in S_ERR.
// Ports: clk, rst (sync, active-low), bus (toy_warmup_driver_if.slave):
//   cmd_valid/cmd_ready/cmd_data/cmd_op  host command handshake
//   core_datain/core_op                  registered drive to the core
//   core_valid/core_dataout              core completion
//   res_valid/res_data                   result beat to host
//   unlocked/busy/timeout_err            status
module toy_warmup_driver
  import toy_drv_pkg::*;
#(
  parameter int unsigned                    KEY_LEN    = KEY_LEN_DEF,
  parameter logic [KEY_LEN*KEY_W-1:0]       KEY        = KEY_DEF,
  parameter int unsigned                    HOLD_CYC   = 2,
  parameter int unsigned                    WARM_CYC   = 2,
  parameter int unsigned                    FIFO_DEPTH = 4,
  parameter int unsigned                    TIMEOUT    = 31
) (
  input logic                clk,
  input logic                rst,
  toy_warmup_driver_if.slave bus
);

  localparam int unsigned KIDX_W = cnt_width(KEY_LEN - 1);
  localparam int unsigned CNT_W  = cnt_width((HOLD_CYC > WARM_CYC) ? HOLD_CYC : WARM_CYC);
  localparam int unsigned TMR_W  = cnt_width(TIMEOUT);

  state_t            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [KIDX_W-1:0] key_idx_q,   key_idx_d;
  logic [TMR_W-1:0]  timer_q,     timer_d;
  key_word_t         core_q,      core_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q,  res_data_d;
  logic              unlocked_q,  unlocked_d;
  logic              busy_q,      busy_d;
  logic              err_q,       err_d;

  key_word_t         key_rom [KEY_LEN];
  key_word_t         cmd_word;
  key_word_t         fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic              cmd_ready_c;

  // Unpack the key so word 0 (MS slot) is key_rom[0].
  for (genvar g = 0; g < KEY_LEN; g++) begin : g_key_rom
    assign key_rom[g] = KEY[(KEY_LEN-1-g)*KEY_W +: KEY_W];
  end

  assign cmd_word    = '{op: bus.cmd_op, data: bus.cmd_data};
  assign cmd_ready_c = ~fifo_full & (state_q != S_ERR) & rst;
  assign fifo_push   = bus.cmd_valid & cmd_ready_c;

  toy_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (fifo_flush),
    .push       (fifo_push),
    .push_data  (cmd_word),
    .pop        (fifo_pop),
    .pop_data_c (fifo_head),
    .full_c     (fifo_full),
    .empty_c    (fifo_empty)
  );

  // State and output registers; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_WARM;
      cnt_q       <= '0;
      key_idx_q   <= '0;
      timer_q     <= '0;
      core_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      unlocked_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_idx_q   <= key_idx_d;
      timer_q     <= timer_d;
      core_q      <= core_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      unlocked_q  <= unlocked_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_idx_d   = key_idx_q;
    timer_d     = timer_q;
    core_d      = core_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    unlocked_d  = unlocked_q;
    err_d       = err_q;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;

    case (state_q)
      S_WARM: begin
        // Key word 0 is loaded on the exit edge so it shows right after the idle gap.
        if (cnt_q == CNT_W'(WARM_CYC - 1)) begin
          cnt_d     = '0;
          key_idx_d = '0;
          core_d    = key_rom[0];
          state_d   = S_KEY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_KEY: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          cnt_d = '0;
          if (key_idx_q == KIDX_W'(KEY_LEN - 1)) begin
            core_d     = '0;
            unlocked_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            key_idx_d = key_idx_q + KIDX_W'(1);
            core_d    = key_rom[key_idx_q + KIDX_W'(1)];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          core_d   = fifo_head;
          timer_d  = '0;
          state_d  = S_ISSUE;
        end
      end

      // Timer runs from the issue cycle so it equals the S_WAIT cycle number.
      S_ISSUE: begin
        timer_d = timer_q + TMR_W'(1);
        state_d = S_WAIT;
      end

      // A completion in the same cycle as the timeout takes priority.
      S_WAIT: begin
        if (bus.core_valid) begin
          res_valid_d = 1'b1;
          res_data_d  = bus.core_dataout;
          core_d      = '0;
          state_d     = S_IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          err_d      = 1'b1;
          core_d     = '0;
          fifo_flush = 1'b1;
          state_d    = S_ERR;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_WARM;
      end
    endcase

    busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
  end

  assign bus.cmd_ready   = cmd_ready_c;
  assign bus.core_op     = core_q.op;
  assign bus.core_datain = core_q.data;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.unlocked    = unlocked_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_toy_warmup_driver.sv
// Directed-plus-random bench for toy_warmup_driver. The bench plays host and
// core stub; expected key timing, issue order, capacity and timeout point are
// derived arithmetically from the block's parameters.
module tb_toy_warmup_driver;

  localparam int WARM  = 2;
  localparam int HOLD  = 2;
  localparam int NKEY  = 4;
  localparam int DEPTH = 4;
  localparam int TMO   = 31;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [9:0] key_tab [NKEY];
  logic [7:0] last_res;
  logic [9:0] q [$];

  toy_warmup_driver_if bus ();

  toy_warmup_driver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] core_word();
    return 32'({bus.core_op, bus.core_datain});
  endfunction

  // Word expected on the core bus t edges after reset release.
  function automatic logic [9:0] exp_key(input int t);
    int idx;
    if (t < WARM) return 10'h0;
    idx = (t - WARM) / HOLD;
    return (idx < NKEY) ? key_tab[idx] : 10'h0;
  endfunction

  function automatic logic exp_unlocked(input int t);
    return (t >= WARM) && ((t - WARM) / HOLD >= NKEY);
  endfunction

  task automatic do_reset(input int n);
    rst            = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.core_valid = 1'b0;
    repeat (n) step();
    chk("rst_core",      core_word(),          32'h0);
    chk("rst_res_valid", 32'(bus.res_valid),   32'h0);
    chk("rst_res_data",  32'(bus.res_data),    32'h0);
    chk("rst_unlocked",  32'(bus.unlocked),    32'h0);
    chk("rst_busy",      32'(bus.busy),        32'h0);
    chk("rst_timeout",   32'(bus.timeout_err), 32'h0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready),   32'h0);
    last_res = 8'h00;
    rst      = 1'b1;
  endtask

  task automatic play_key(input bit spurious);
    for (int t = 1; t <= WARM + HOLD * NKEY; t++) begin
      if (spurious) begin
        bus.core_valid   = 1'($urandom);
        bus.core_dataout = 8'($urandom);
      end
      step();
      if (t == 1) chk("warm_cmd_ready", 32'(bus.cmd_ready), 32'h1);
      chk($sformatf("key_core_t%0d", t), core_word(), 32'(exp_key(t)));
      chk($sformatf("key_unlocked_t%0d", t), 32'(bus.unlocked), 32'(exp_unlocked(t)));
      chk($sformatf("key_res_valid_t%0d", t), 32'(bus.res_valid), 32'h0);
      chk($sformatf("key_busy_t%0d", t), 32'(bus.busy), 32'h0);
    end
    bus.core_valid = 1'b0;
  endtask

  // Present one command; DUT must be idle with nothing buffered.
  task automatic push_one(input logic [9:0] cmd);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = cmd[9:8];
    bus.cmd_data  = cmd[7:0];
    chk("push_ready", 32'(bus.cmd_ready), 32'h1);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  // Starting just before the edge that pops cmd: check the issue, then
  // complete it d edges after the pop edge with result resp.
  task automatic serve(input logic [9:0] cmd, input int d, input logic [7:0] resp);
    step();
    chk("issue_core",      core_word(),        32'(cmd));
    chk("issue_busy",      32'(bus.busy),      32'h1);
    chk("issue_res_valid", 32'(bus.res_valid), 32'h0);
    chk("issue_res_hold",  32'(bus.res_data),  32'(last_res));
    repeat (d - 1) step();
    chk("wait_core_held",  core_word(),          32'(cmd));
    chk("wait_no_timeout", 32'(bus.timeout_err), 32'h0);
    bus.core_valid   = 1'b1;
    bus.core_dataout = resp;
    step();
    bus.core_valid   = 1'b0;
    bus.core_dataout = 8'($urandom);
    chk("res_valid",   32'(bus.res_valid),   32'h1);
    chk("res_data",    32'(bus.res_data),    32'(resp));
    chk("res_core",    core_word(),          32'h0);
    chk("res_busy",    32'(bus.busy),        32'h0);
    chk("res_timeout", 32'(bus.timeout_err), 32'h0);
    last_res = resp;
  endtask

  initial begin
    logic [9:0] cmd;
    logic [7:0] resp;
    int         d;
    bit         ready_exp;

    key_tab[0] = {2'd1, 8'hA5};
    key_tab[1] = {2'd0, 8'hC3};
    key_tab[2] = {2'd2, 8'h5A};
    key_tab[3] = {2'd3, 8'h3C};
    bus.cmd_valid    = 1'b0;
    bus.cmd_op       = 2'd0;
    bus.cmd_data     = 8'h00;
    bus.core_valid   = 1'b0;
    bus.core_dataout = 8'h00;
    last_res         = 8'h00;

    // Reset and key play with spurious completions during warm-up/key.
    do_reset(3);
    play_key(1'b1);

    // Spurious completion while idle is ignored.
    for (int i = 0; i < 3; i++) begin
      bus.core_valid   = 1'b1;
      bus.core_dataout = 8'($urandom);
      step();
      chk("idle_spurious_res_valid", 32'(bus.res_valid), 32'h0);
      chk("idle_spurious_busy",      32'(bus.busy),      32'h0);
      chk("idle_spurious_res_data",  32'(bus.res_data),  32'h0);
    end
    bus.core_valid = 1'b0;

    // Single directed command.
    push_one({2'd1, 8'h3C});
    serve({2'd1, 8'h3C}, 5, 8'hC3);

    // Random commands; first two pin the earliest and the timeout-coincident completion.
    for (int i = 0; i < 6; i++) begin
      cmd  = 10'($urandom);
      resp = 8'($urandom);
      d    = (i == 0) ? 2 : (i == 1) ? TMO + 1 : int'($urandom_range(2, TMO + 1));
      push_one(cmd);
      serve(cmd, d, resp);
    end

    // Backpressure: six back-to-back offers while the core stalls.
    q.delete();
    for (int j = 0; j < 6; j++) begin
      cmd = 10'($urandom);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = cmd[9:8];
      bus.cmd_data  = cmd[7:0];
      ready_exp = ((j == 0) ? 0 : j - 1) < DEPTH;
      chk($sformatf("bp_ready_%0d", j), 32'(bus.cmd_ready), 32'(ready_exp));
      if (ready_exp) q.push_back(cmd);
      step();
      if (j == 1) begin
        chk("bp_first_issue", core_word(),   32'(q[0]));
        chk("bp_first_busy",  32'(bus.busy), 32'h1);
      end
    end
    bus.cmd_valid = 1'b0;
    chk("bp_full_ready", 32'(bus.cmd_ready), 32'h0);
    resp = 8'($urandom);
    bus.core_valid   = 1'b1;
    bus.core_dataout = resp;
    step();
    bus.core_valid = 1'b0;
    chk("bp_first_res_valid", 32'(bus.res_valid), 32'h1);
    chk("bp_first_res_data",  32'(bus.res_data),  32'(resp));
    last_res = resp;
    void'(q.pop_front());
    while (q.size() > 0) begin
      cmd = q.pop_front();
      serve(cmd, int'($urandom_range(2, 8)), 8'($urandom));
    end

    // Reset in the middle of a command with more commands buffered.
    cmd = 10'($urandom);
    push_one(cmd);
    repeat (3) step();
    chk("mid_busy", 32'(bus.busy), 32'h1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd2;
    bus.cmd_data  = 8'h77;
    chk("mid_push_ready", 32'(bus.cmd_ready), 32'h1);
    repeat (2) step();
    bus.cmd_valid = 1'b0;
    do_reset(1);
    play_key(1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_fifo_empty_busy", 32'(bus.busy), 32'h0);
      chk("post_rst_fifo_empty_core", core_word(),   32'h0);
    end

    // Timeout: no completion ever arrives; extra commands get flushed.
    cmd = 10'($urandom);
    push_one(cmd);
    step();
    chk("to_issue_core", core_word(), 32'(cmd));
    for (int k = 1; k <= TMO + 1; k++) begin
      if (k == 2) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd1;
        bus.cmd_data  = 8'h55;
        chk("to_push_ready", 32'(bus.cmd_ready), 32'h1);
      end
      if (k == 4) bus.cmd_valid = 1'b0;
      step();
      chk($sformatf("to_err_k%0d", k), 32'(bus.timeout_err), 32'(k == TMO + 1));
    end
    chk("to_core",      core_word(),        32'h0);
    chk("to_busy",      32'(bus.busy),      32'h0);
    chk("to_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    chk("to_unlocked",  32'(bus.unlocked),  32'h1);
    for (int i = 0; i < 3; i++) begin
      bus.core_valid   = 1'b1;
      bus.core_dataout = 8'($urandom);
      bus.cmd_valid    = 1'b1;
      step();
      chk("err_res_valid", 32'(bus.res_valid),   32'h0);
      chk("err_res_data",  32'(bus.res_data),    32'(last_res));
      chk("err_sticky",    32'(bus.timeout_err), 32'h1);
      chk("err_busy",      32'(bus.busy),        32'h0);
      chk("err_ready",     32'(bus.cmd_ready),   32'h0);
    end
    bus.core_valid = 1'b0;
    bus.cmd_valid  = 1'b0;

    // Only reset clears the sticky error.
    do_reset(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
